// File: rtl/seq_det_ctrl.sv
// Run controller for an overlapping Moore sequence detector.
// Captures a pattern and a length, clears the detector, streams the pattern MSB-first into the
// detector and counts its output pulses, then pulses done with the final hit count.
// Optional feature macro: SEQ_CTRL_STOP_ON_HIT_EN ends a run at the first counted hit.
module seq_det_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pat,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             det_rst,
  output logic             det_x,
  input  logic             det_z
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [CNT_W-1:0] LenMax = CNT_W'(W);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             det_rst_q, det_rst_d;
  logic             det_x_q, det_x_d;

  logic             count_en;
  logic             stop_hit;
  logic [CNT_W-1:0] bit_idx;
  logic [W-1:0]     pat_sh;

`ifdef SEQ_CTRL_STOP_ON_HIT_EN
  assign stop_hit = 1'b1;
`else
  assign stop_hit = 1'b0;
`endif

  // z in the first SHIFT cycle still shows the detector's reset state, so it is skipped.
  assign count_en = det_z & (((state_q == StShift) && (i_q != '0)) || (state_q == StDrain));

  // Next-state, capture and counting; outputs are derived from the next state so they register.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    i_d       = i_q;
    hit_cnt_d = hit_cnt_q;

    if (count_en && (hit_cnt_q != CntMax)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          pat_d     = pat;
          len_d     = (len > LenMax) ? LenMax : len;
          hit_cnt_d = '0;
          state_d   = StClear;
        end
      end
      StClear: begin
        i_d     = '0;
        state_d = (len_q == '0) ? StDone : StShift;
      end
      StShift: begin
        if (count_en && stop_hit) begin
          state_d = StDone;
        end else if (i_q == (len_q - CNT_W'(1))) begin
          state_d = StDrain;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bit_idx   = len_q - CNT_W'(1) - i_d;
    pat_sh    = pat_q >> bit_idx;
    busy_d    = (state_d == StClear) || (state_d == StShift) || (state_d == StDrain);
    done_d    = (state_d == StDone);
    det_rst_d = (state_d != StClear);
    det_x_d   = (state_d == StShift) ? pat_sh[0] : 1'b0;
  end

  // State and registered outputs; reset forces every output low, including det_rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      len_q     <= '0;
      i_q       <= '0;
      hit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_rst_q <= 1'b0;
      det_x_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      i_q       <= i_d;
      hit_cnt_q <= hit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      det_rst_q <= det_rst_d;
      det_x_q   <= det_x_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit_cnt = hit_cnt_q;
  assign det_rst = det_rst_q;
  assign det_x   = det_x_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl paired with a behavioural overlapping "101" Moore detector.
module tb_seq_det_ctrl;
  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     pat;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;
  logic             det_rst;
  logic             det_x;
  logic             det_z;

  int total = 0;
  int bad   = 0;

  seq_det_ctrl #(.W(W), .CNT_W(CNT_W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pat     (pat),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .hit_cnt (hit_cnt),
    .det_rst (det_rst),
    .det_x   (det_x),
    .det_z   (det_z)
  );

  always #5 clk = ~clk;

  // Overlapping Moore detector for "101": 0 idle, 1 saw 1, 2 saw 10, 3 saw 101.
  logic [1:0] ds_q;
  always_ff @(posedge clk or negedge det_rst) begin
    if (!det_rst) begin
      ds_q <= 2'd0;
    end else begin
      case (ds_q)
        2'd0:    ds_q <= det_x ? 2'd1 : 2'd0;
        2'd1:    ds_q <= det_x ? 2'd1 : 2'd2;
        2'd2:    ds_q <= det_x ? 2'd3 : 2'd0;
        default: ds_q <= det_x ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign det_z = (ds_q == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: cycle c is the c-th cycle after the edge that samples start.
  // start is re-pulsed (with junk pat/len) in cycles pa and pb; both must be ignored.
  task automatic run(input string name, input logic [15:0] p, input logic [4:0] l,
                     input int nbits, input int done_cyc, input logic [4:0] exp_hits,
                     input int pa, input int pb);
    logic exp_x;
    pat   = p;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    pat   = 16'h0000;
    len   = 5'd1;
    for (int c = 1; c <= done_cyc; c++) begin
      start = (c == pa) || (c == pb);
      exp_x = 1'b0;
      if (c >= 2 && c < 2 + nbits && c < done_cyc) exp_x = p[nbits - 1 - (c - 2)];
      chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c < done_cyc));
      chk($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == done_cyc));
      chk($sformatf("%s det_rst c%0d", name, c), 32'(det_rst), 32'(c != 1));
      chk($sformatf("%s det_x c%0d", name, c), 32'(det_x), 32'(exp_x));
      if (c == done_cyc) chk($sformatf("%s hit_cnt", name), 32'(hit_cnt), 32'(exp_hits));
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s idle busy", name), 32'(busy), 32'd0);
    chk($sformatf("%s idle done", name), 32'(done), 32'd0);
    chk($sformatf("%s held hit_cnt", name), 32'(hit_cnt), 32'(exp_hits));
    tick();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    pat   = '0;
    len   = '0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst det_rst", 32'(det_rst), 32'd0);
    chk("rst det_x", 32'(det_x), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    chk("post rst det_rst", 32'(det_rst), 32'd1);
    chk("post rst busy", 32'(busy), 32'd0);
    tick();

`ifdef SEQ_CTRL_STOP_ON_HIT_EN
    // Hit counted in SHIFT cycle 5 ends the run; DONE in cycle 6.
    run("basic", 16'h0015, 5'd5, 5, 6, 5'd1, 3, 6);
`else
    run("basic", 16'h0015, 5'd5, 5, 8, 5'd2, 3, 8);
`endif
    run("zero", 16'h0015, 5'd0, 0, 2, 5'd0, 0, 2);
    run("clamp", 16'hFFFF, 5'd31, 16, 19, 5'd0, 3, 19);
    run("lastbit", 16'h0005, 5'd3, 3, 6, 5'd1, 3, 6);

    // Abort a run in cycle 6 (SHIFT, det_x=1, hit_cnt=1 in the default build).
    pat   = 16'h0015;
    len   = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort hit_cnt", 32'(hit_cnt), 32'd0);
    chk("abort det_x", 32'(det_x), 32'd0);
    chk("abort det_rst", 32'(det_rst), 32'd0);
    tick();
    tick();
    chk("abort held det_rst", 32'(det_rst), 32'd0);
    chk("abort held busy", 32'(busy), 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("abort release det_rst", 32'(det_rst), 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("abort no done k%0d", k), 32'(done), 32'd0);
      chk($sformatf("abort idle busy k%0d", k), 32'(busy), 32'd0);
      tick();
    end

    // A fresh run after the abort still behaves normally.
    run("after abort", 16'h0005, 5'd3, 3, 6, 5'd1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
